// File: rtl/clock_ctrl_pkg.sv
// Mode encodings and sizing helpers shared by the clock mode controller files.
package clock_ctrl_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_CLOCK    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SET_HOUR = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SET_MIN  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SET_SEC  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ALM_HOUR = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ALM_MIN  = 3'd5;

  function automatic int tmo_cnt_w(input int timeout_sec);
    return $clog2(timeout_sec + 1);
  endfunction

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    case (m)
      MODE_CLOCK:    r = MODE_SET_HOUR;
      MODE_SET_HOUR: r = MODE_SET_MIN;
      MODE_SET_MIN:  r = MODE_SET_SEC;
      MODE_SET_SEC:  r = MODE_ALM_HOUR;
      MODE_ALM_HOUR: r = MODE_ALM_MIN;
      MODE_ALM_MIN:  r = MODE_CLOCK;
      default:       r = MODE_CLOCK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Switch, tick and command signals between the board, the controller and TimeControl.
interface clock_mode_ctrl_if;
  import clock_ctrl_pkg::*;

  logic              SW_F1;
  logic              SW_F2;
  logic              TICK_1HZ;
  logic [MODE_W-1:0] MODE;
  logic              INC_HOUR;
  logic              INC_MIN;
  logic              CLR_SEC;
  logic              ALARM_SEL;
  logic              ALARM_EN;
  logic              RUN_EN;
  logic              BLINK;

  modport master (
    output SW_F1, SW_F2, TICK_1HZ,
    input  MODE, INC_HOUR, INC_MIN, CLR_SEC, ALARM_SEL, ALARM_EN, RUN_EN, BLINK
  );

  modport slave (
    input  SW_F1, SW_F2, TICK_1HZ,
    output MODE, INC_HOUR, INC_MIN, CLR_SEC, ALARM_SEL, ALARM_EN, RUN_EN, BLINK
  );

endinterface

// File: rtl/clock_mode_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse.
module sw_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= RAW;
      sync2_q <= sync1_q;
    end
  end

  // Level flips on the DB_CYCLES-th consecutive disagreeing sample; press marks rising flips only.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: debounced F1/F2 drive the mode FSM, edit commands,
// alarm arming, display blink and the inactivity timeout back to CLOCK.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int TIMEOUT_SEC = 10
) (
  input logic              CLK,
  input logic              RST,
  clock_mode_ctrl_if.slave bus
);

  localparam int TW = tmo_cnt_w(TIMEOUT_SEC);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              inc_hour_q, inc_hour_d;
  logic              inc_min_q, inc_min_d;
  logic              clr_sec_q, clr_sec_d;
  logic              alarm_sel_q, alarm_sel_d;
  logic              alarm_en_q, alarm_en_d;
  logic              run_en_q, run_en_d;
  logic              blink_q, blink_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic press_f1_s, press_f2_s, lvl_f1_s, lvl_f2_s;
  logic any_press_s, mode_legal_s, timeout_s, mode_chg_s;
  logic unused_levels_s;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_f1 (
    .CLK   (CLK),
    .RST   (RST),
    .RAW   (bus.SW_F1),
    .LEVEL (lvl_f1_s),
    .PRESS (press_f1_s)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_f2 (
    .CLK   (CLK),
    .RST   (RST),
    .RAW   (bus.SW_F2),
    .LEVEL (lvl_f2_s),
    .PRESS (press_f2_s)
  );

  assign unused_levels_s = lvl_f1_s ^ lvl_f2_s;
  assign any_press_s     = press_f1_s | press_f2_s;
  assign mode_legal_s    = (mode_q <= MODE_ALM_MIN);
  // Terminal tick only; a press in the same cycle takes priority in the decode below.
  assign timeout_s       = bus.TICK_1HZ & (mode_q != MODE_CLOCK) &
                           (tmo_cnt_q == TW'(TIMEOUT_SEC - 1));

  always_comb begin
    mode_d     = mode_q;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    clr_sec_d  = 1'b0;
    alarm_en_d = alarm_en_q;
    if (!mode_legal_s) begin
      mode_d = MODE_CLOCK;
    end else if (press_f1_s) begin
      mode_d = next_mode(mode_q);
    end else if (press_f2_s) begin
      case (mode_q)
        MODE_CLOCK:                   alarm_en_d = ~alarm_en_q;
        MODE_SET_HOUR, MODE_ALM_HOUR: inc_hour_d = 1'b1;
        MODE_SET_MIN, MODE_ALM_MIN:   inc_min_d  = 1'b1;
        MODE_SET_SEC:                 clr_sec_d  = 1'b1;
        default:                      alarm_en_d = alarm_en_q;
      endcase
    end else if (timeout_s) begin
      mode_d = MODE_CLOCK;
    end else begin
      mode_d = mode_q;
    end
  end

  // Mode-derived outputs are computed from mode_d so they register alongside MODE.
  always_comb begin
    mode_chg_s  = (mode_d != mode_q);
    alarm_sel_d = (mode_d == MODE_ALM_HOUR) || (mode_d == MODE_ALM_MIN);
    run_en_d    = (mode_d != MODE_SET_SEC);
    tmo_cnt_d   = tmo_cnt_q;
    blink_d     = blink_q;
    if ((mode_d == MODE_CLOCK) || any_press_s || mode_chg_s) begin
      tmo_cnt_d = '0;
    end else if (bus.TICK_1HZ) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (mode_d == MODE_CLOCK) begin
      blink_d = 1'b0;
    end else if (mode_chg_s) begin
      blink_d = 1'b1;
    end else if (bus.TICK_1HZ) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q      <= MODE_CLOCK;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
      alarm_sel_q <= 1'b0;
      alarm_en_q  <= 1'b0;
      run_en_q    <= 1'b1;
      blink_q     <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      clr_sec_q   <= clr_sec_d;
      alarm_sel_q <= alarm_sel_d;
      alarm_en_q  <= alarm_en_d;
      run_en_q    <= run_en_d;
      blink_q     <= blink_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.MODE      = mode_q;
  assign bus.INC_HOUR  = inc_hour_q;
  assign bus.INC_MIN   = inc_min_q;
  assign bus.CLR_SEC   = clr_sec_q;
  assign bus.ALARM_SEL = alarm_sel_q;
  assign bus.ALARM_EN  = alarm_en_q;
  assign bus.RUN_EN    = run_en_q;
  assign bus.BLINK     = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl against a press/tick-level reference model.
module tb_clock_mode_ctrl;

  localparam int DB  = 4;
  localparam int TMO = 10;
  localparam int LAT = DB + 2;
  localparam logic [9:0] RESET_VEC = 10'b000_0000_010;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  // Reference state: mode number, alarm flag, blink phase, ticks since last activity.
  int   m_mode;
  bit   m_alarm;
  bit   m_blink;
  int   m_ticks;
  bit   m_ih, m_im, m_cs;

  clock_mode_ctrl_if bus_if ();

  clock_mode_ctrl #(.DB_CYCLES(DB), .TIMEOUT_SEC(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_mode = 0; m_alarm = 1'b0; m_blink = 1'b0; m_ticks = 0;
    m_ih = 1'b0; m_im = 1'b0; m_cs = 1'b0;
  endtask

  task automatic model_step(input bit p1, input bit p2, input bit tk);
    int prev;
    prev = m_mode;
    m_ih = 1'b0; m_im = 1'b0; m_cs = 1'b0;
    if (p1) begin
      m_mode  = (m_mode + 1) % 6;
      m_ticks = 0;
    end else if (p2) begin
      m_ticks = 0;
      if (m_mode == 0) m_alarm = !m_alarm;
      else if (m_mode == 1 || m_mode == 4) m_ih = 1'b1;
      else if (m_mode == 2 || m_mode == 5) m_im = 1'b1;
      else m_cs = 1'b1;
    end else if (tk && m_mode != 0) begin
      m_ticks = m_ticks + 1;
      if (m_ticks >= TMO) begin
        m_mode  = 0;
        m_ticks = 0;
      end
    end
    if (m_mode == 0) m_blink = 1'b0;
    else if (m_mode != prev) m_blink = 1'b1;
    else if (tk) m_blink = !m_blink;
  endtask

  function automatic logic [9:0] model_vec();
    logic [2:0] mm;
    mm = 3'(m_mode);
    return {mm, m_ih, m_im, m_cs, (m_mode == 4 || m_mode == 5), m_alarm, (m_mode != 3), m_blink};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus_if.MODE, bus_if.INC_HOUR, bus_if.INC_MIN, bus_if.CLR_SEC,
            bus_if.ALARM_SEL, bus_if.ALARM_EN, bus_if.RUN_EN, bus_if.BLINK};
  endfunction

  // Drives one button gesture (plus optional periodic ticks), checking every cycle.
  task automatic run(input string tag, input bit f1, input bit f2, input int hold,
                     input int len_min, input int tick_every, input int tick_ofs);
    int         len;
    bit         tk, p1, p2;
    logic [9:0] act, exp_v;
    len = len_min;
    if (len < hold + DB + 5) len = hold + DB + 5;
    if (len < LAT + 2) len = LAT + 2;
    for (int k = 0; k < len; k++) begin
      tk = (tick_every > 1) && (k >= tick_ofs) && (((k - tick_ofs) % tick_every) == 0);
      bus_if.SW_F1    = f1 && (k < hold);
      bus_if.SW_F2    = f2 && (k < hold);
      bus_if.TICK_1HZ = tk;
      @(posedge CLK);
      p1 = f1 && (hold >= DB) && (k == LAT);
      p2 = f2 && (hold >= DB) && (k == LAT);
      model_step(p1, p2, tk);
      @(negedge CLK);
      act   = dut_vec();
      exp_v = model_vec();
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b (mode,ih,im,cs,asel,aen,run,blink) t=%0t",
                 tag, k, act, exp_v, $time);
      end
    end
    bus_if.SW_F1 = 1'b0; bus_if.SW_F2 = 1'b0; bus_if.TICK_1HZ = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] act;
    RST = 1'b0;
    bus_if.SW_F1 = 1'b0; bus_if.SW_F2 = 1'b0; bus_if.TICK_1HZ = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    act = dut_vec();
    n_checks++;
    if (act !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", act, RESET_VEC);
    end
    RST = 1'b1;
    run("idle", 1'b0, 1'b0, 0, 20, 0, 0);
  endtask

  task automatic test_debounce();
    run("glitch1", 1'b1, 1'b0, 1, 12, 0, 0);
    run("glitch3", 1'b1, 1'b0, 3, 12, 0, 0);
    run("f1_hold8", 1'b1, 1'b0, 8, 16, 0, 0);
  endtask

  task automatic test_min_edit();
    run("to_set_min", 1'b1, 1'b0, 6, 12, 0, 0);
    for (int i = 0; i < 3; i++) run("inc_min", 1'b0, 1'b1, 5 + i, 12, 0, 0);
    run("inc_min_held", 1'b0, 1'b1, 50, 60, 0, 0);
  endtask

  task automatic test_sec_and_alarm();
    run("to_set_sec", 1'b1, 1'b0, 6, 12, 0, 0);
    run("clr_sec", 1'b0, 1'b1, 6, 12, 0, 0);
    run("to_alm_hour", 1'b1, 1'b0, 6, 12, 0, 0);
    run("alm_inc_hour", 1'b0, 1'b1, 6, 12, 0, 0);
    run("to_alm_min", 1'b1, 1'b0, 6, 12, 0, 0);
    run("wrap_clock", 1'b1, 1'b0, 6, 12, 0, 0);
  endtask

  task automatic test_alarm_toggle();
    run("alarm_on", 1'b0, 1'b1, 6, 12, 0, 0);
    run("alarm_off", 1'b0, 1'b1, 6, 12, 0, 0);
    run("f1_f2_same", 1'b1, 1'b1, 6, 12, 0, 0);
  endtask

  task automatic test_timeout();
    run("tmo_plain", 1'b0, 1'b0, 0, 44, 4, 1);
    run("to_set_hour", 1'b1, 1'b0, 6, 12, 0, 0);
    run("ticks8", 1'b0, 1'b0, 0, 32, 4, 1);
    run("press_tick9", 1'b0, 1'b1, 6, 12, 100, 6);
    run("ticks_after", 1'b0, 1'b0, 0, 44, 4, 1);
    run("to_set_hour2", 1'b1, 1'b0, 6, 12, 0, 0);
    run("ticks9", 1'b0, 1'b0, 0, 36, 4, 1);
    run("press_terminal", 1'b0, 1'b1, 6, 12, 100, 6);
    run("ticks_final", 1'b0, 1'b0, 0, 44, 4, 1);
  endtask

  task automatic test_reset_mid_edit();
    logic [9:0] act;
    for (int i = 0; i < 6 && m_mode != 2; i++) run("seek_set_min", 1'b1, 1'b0, 6, 12, 0, 0);
    bus_if.SW_F2 = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    act = dut_vec();
    n_checks++;
    if (act !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset_mid_edit: got %b expected %b", act, RESET_VEC);
    end
    bus_if.SW_F2 = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    run("post_reset_idle", 1'b0, 1'b0, 0, 12, 0, 0);
  endtask

  task automatic test_random();
    int  sel, hold, te, ofs, len;
    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 12));
      te   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0;
      ofs  = int'($urandom_range(0, 5));
      len  = int'($urandom_range(8, 20));
      run("random", (sel == 0) || (sel == 2), (sel != 0), hold, len, te, ofs);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_debounce();
    test_min_edit();
    test_sec_and_alarm();
    test_alarm_toggle();
    test_timeout();
    test_reset_mid_edit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
User-interface sequencer for the digital clock's TimeControl datapath.
- Debounces the two raw push-buttons SW_F1 and SW_F2.
- Walks a mode FSM: run, set time, set alarm.
- Issues single-cycle field-edit commands and a run-enable to the timekeeping and alarm registers.
- Sits between the board switches and TimeControl / alarm compare logic.

Parameters:
- DB_CYCLES, 4, consecutive stable samples needed before a debounced level changes (≥2).
- TIMEOUT_SEC, 10, TICK_1HZ pulses with no button press in any set mode before forced return to CLOCK mode (≥1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- SW_F1  in  1  raw mode button, active-high, asynchronous to CLK.
- SW_F2  in  1  raw adjust button, active-high, asynchronous to CLK.
- TICK_1HZ  in  1  one-cycle pulse once per second, from the prescaler.
- MODE  out  3  current mode encoding.
- INC_HOUR  out  1  one-cycle increment command, hour field.
- INC_MIN  out  1  one-cycle increment command, minute field.
- CLR_SEC  out  1  one-cycle clear command, seconds field.
- ALARM_SEL  out  1  1 = INC_* targets the alarm registers; 0 = time registers.
- ALARM_EN  out  1  alarm armed flag.
- RUN_EN  out  1  seconds counting enable to the datapath.
- BLINK  out  1  display blink phase for the field being edited.

Behaviour:
- Reset (RST=0, asynchronous):
  - MODE=CLOCK; INC_HOUR=INC_MIN=CLR_SEC=0; ALARM_SEL=0; ALARM_EN=0; RUN_EN=1; BLINK=0.
  - Debouncer and timeout state cleared.
  - Reset takes effect immediately, including mid-press or mid-edit.
- Synchroniser: each raw switch goes through a 2-flop synchroniser.
- Debounce:
  - Debounced level flips only after the synchronised input differs from it on DB_CYCLES consecutive edges.
  - Any agreeing sample restarts the count.
  - Press pulse = debounced rising edge; exactly one cycle per press, including while held.
  - Release generates nothing.
- Latency: raw rise set up before edge e0 → command output high for the one cycle after edge e0+DB_CYCLES+2 (e0+6 at default).
- Mode encoding: CLOCK=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, ALM_HOUR=4, ALM_MIN=5. Codes 6–7 are illegal and recover to CLOCK on the next edge.
- F1 press: MODE advances CLOCK→SET_HOUR→SET_MIN→SET_SEC→ALM_HOUR→ALM_MIN→CLOCK.
- F2 press (registered outputs, one cycle, same edge the FSM acts):
  - CLOCK: toggle ALARM_EN.
  - SET_HOUR: INC_HOUR.
  - SET_MIN: INC_MIN.
  - SET_SEC: CLR_SEC.
  - ALM_HOUR: INC_HOUR.
  - ALM_MIN: INC_MIN.
- ALARM_SEL is 1 in ALM_HOUR/ALM_MIN, else 0. It is a function of the registered MODE, so it is valid whenever an INC_* pulse is high.
- RUN_EN=0 only in SET_SEC; 1 otherwise.
- Simultaneous F1 and F2 presses in the same cycle: F1 acts, F2 is discarded, no command is issued.
- BLINK:
  - Toggles on each TICK_1HZ while MODE≠CLOCK.
  - Forced 0 in CLOCK.
  - Set to 1 on every mode change into a set mode.
- Timeout:
  - Counter counts TICK_1HZ while MODE≠CLOCK.
  - Cleared on any press, on any mode change, and in CLOCK.
  - When the count reaches TIMEOUT_SEC, MODE←CLOCK on the next edge and no command is issued.
  - A press in the same cycle as the terminal tick wins: the press is executed and the counter clears.
- Commands never issue in consecutive cycles from one press. Two commands are at least DB_CYCLES·2 cycles apart.

Decomposition:
- Package clock_ctrl_pkg:
  - mode encodings as localparams: MODE_CLOCK … MODE_ALM_MIN;
  - MODE_W=3;
  - timeout counter width function (clog2).
- Sub-module sw_debounce(CLK, RST, RAW, LEVEL, PRESS): synchroniser, debounce counter, edge pulse. Instantiated twice, parameterised by DB_CYCLES.
- FSM, command decode and timeout counter stay in clock_mode_ctrl.

Test Plan:
- Reset then idle 20 cycles → MODE=0, RUN_EN=1, ALARM_EN=0, all command outputs 0. Assert RST=0 mid-edit in SET_MIN → all outputs return to reset values that same cycle, without waiting for a clock edge.
- SW_F1 held high 1 cycle, then 3 cycles (DB_CYCLES=4) → no MODE change. Held 8 cycles → MODE 0→1 exactly once, at edge e0+6.
- F1 ×2 (MODE=2), then F2 ×3 presses → three INC_MIN pulses, each 1 cycle, ALARM_SEL=0. Hold F2 for 50 cycles → exactly one INC_MIN pulse.
- F1 to SET_SEC → RUN_EN=0. F2 → CLR_SEC 1 cycle. F1 → MODE=4, RUN_EN=1. F2 → INC_HOUR with ALARM_SEL=1. F1, F1 → MODE wraps 5→0.
- In CLOCK, F2 → ALARM_EN 0→1; F2 again → 1→0. F1 and F2 raw rise on the same edge → MODE=1, no ALARM_EN change, no INC_HOUR.
- In SET_HOUR, apply 10 TICK_1HZ pulses with no press → MODE=0 after the 10th; BLINK toggled 9 times then forced 0. Repeat with an F2 press at tick 9 → no timeout until 10 further ticks.
